serial_signed_sub_with_overflow: RTL and testbench
==================================================

Name: serial_signed_sub_with_overflow

Overview:
- Bit-serial two's-complement subtractor: computes diff = a - b at WIDTH bits and flags signed overflow.
- Counterpart to the team's combinational signed adder: the subtract direction, built with one full-adder slice iterated over WIDTH cycles.
- Valid/ready on both operand and result sides; sits between an operand producer and a result consumer in the arithmetic section.

Parameters:
WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
arg_vld  input  1  operands a, b valid
arg_rdy  output  1  block can accept operands
a  input  WIDTH  minuend, two's complement
b  input  WIDTH  subtrahend, two's complement
res_vld  output  1  diff and overflow valid
res_rdy  input  1  consumer accepts result
diff  output  WIDTH  a - b modulo 2^WIDTH (or saturated, see Optional Feature)
overflow  output  1  true signed result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- FSM states: IDLE, BUSY, DONE. Reset -> IDLE.
- Reset values: arg_rdy=1, res_vld=0, diff=0, overflow=0, bit counter=0, carry=0.
- arg_rdy = (state==IDLE); res_vld = (state==DONE). Both are purely state-decoded, no combinational path from inputs.

IDLE:
- On an edge with arg_vld=1: latch a into shift reg A and ~b into shift reg B; carry<=1; counter<=0; -> BUSY.
- a and b are sampled only at this edge; later input changes are ignored.

BUSY:
- Each edge: s = A[0]^B[0]^carry; carry <= majority(A[0],B[0],carry).
- s shifts into the MSB of the result shift reg; A and B shift right; counter++.
- On the edge where counter==WIDTH-1 (the MSB step): overflow <= carry_in_msb ^ carry_out_msb.
  - Equivalent check: (a_msb != b_msb) && (diff_msb != a_msb).
  - Then -> DONE.
- Latency: res_vld rises exactly WIDTH edges after the accepting edge.

DONE:
- diff and overflow are held stable while res_vld=1 and res_rdy=0 (backpressure of unlimited length).
- On an edge with res_rdy=1 -> IDLE.
- A new operand is accepted no earlier than the edge after the return to IDLE. Throughput is one result per WIDTH+2 cycles minimum.

Boundary conditions:
- diff and overflow are updated only in BUSY; their values outside DONE are don't-care to consumers but must be deterministic.
- b = most-negative value: ~b+1 overflows internally. The rules above still give the correct overflow (e.g. 0 - (-8) at WIDTH=4 -> diff=1000, overflow=1).
- rst asserted in any state, including mid-BUSY: next edge forces IDLE and reset values. The partial result is discarded and no res_vld pulse is produced.
- arg_vld while BUSY/DONE is ignored (arg_rdy=0). The producer must hold its operands.

Optional Feature:
- Macro: SERIAL_SUB_SATURATE_EN.
- Defined: when overflow=1 in DONE, diff is clamped instead of wrapping:
  - a non-negative -> 2^(WIDTH-1)-1 (4'b0111 at WIDTH=4)
  - a negative -> -2^(WIDTH-1) (4'b1000)
  - The overflow flag is still reported. Clamping is applied on the MSB step edge, with no extra latency.
- Undefined: diff is the wrapped modulo-2^WIDTH value. No saturation logic is present.

Test Plan:
- WIDTH=4, a=3, b=5, res_rdy=1 -> res_vld 4 edges after accept; diff=4'b1110 (-2), overflow=0; back to IDLE next edge.
- a=7, b=-1 (4'b1111) -> overflow=1; diff=4'b1000 without macro, 4'b0111 with SERIAL_SUB_SATURATE_EN.
- a=-8, b=1 -> overflow=1; diff=4'b0111 without macro, 4'b1000 with macro. Then a=-8, b=-8 -> diff=0, overflow=0.
- a=0, b=-8 -> diff=4'b1000, overflow=1. Change a, b during BUSY -> result unchanged.
- Backpressure: res_rdy=0 for 10 cycles in DONE -> res_vld, diff, overflow stable and arg_rdy=0. Raise res_rdy -> IDLE next edge.
- Assert rst for 1 cycle at BUSY step 2 -> next edge: IDLE, arg_rdy=1, res_vld=0, diff=0, overflow=0. Subsequent a=-3, b=2 -> diff=4'b1011, overflow=0.

Source files
------------

// File: rtl/serial_signed_sub_with_overflow_if.sv
// Operand/result handshake bundle for the bit-serial signed subtractor.
// The producer/consumer side uses the master modport; the subtractor uses the slave modport.
interface serial_signed_sub_with_overflow_if #(
  parameter int WIDTH = 4
);
  logic             arg_vld;
  logic             arg_rdy;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_vld;
  logic             res_rdy;
  logic [WIDTH-1:0] diff;
  logic             overflow;

  modport master (
    output arg_vld,
    output a,
    output b,
    output res_rdy,
    input  arg_rdy,
    input  res_vld,
    input  diff,
    input  overflow
  );

  modport slave (
    input  arg_vld,
    input  a,
    input  b,
    input  res_rdy,
    output arg_rdy,
    output res_vld,
    output diff,
    output overflow
  );
endinterface

// File: rtl/serial_signed_sub_with_overflow.sv
// Bit-serial two's-complement subtractor (diff = a - b) with signed overflow flag.
// Optional clamping of overflowed results is enabled by defining SERIAL_SUB_SATURATE_EN.
module serial_signed_sub_with_overflow #(
  parameter int WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  serial_signed_sub_with_overflow_if.slave     bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    fa_sum = x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    fa_carry = (x & y) | (x & c) | (y & c);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_arg_rdy;
  logic             r_res_vld;

  logic             w_msb_step;
  logic             w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_res_final;

  assign w_msb_step = (r_state == ST_BUSY) && (r_cnt == LAST_CNT);
  assign w_sum      = fa_sum(r_a[0], r_b[0], r_carry);
  assign w_cout     = fa_carry(r_a[0], r_b[0], r_carry);
  // Signed overflow: carry into the sign slice differs from carry out of it.
  assign w_ovf      = r_carry ^ w_cout;
  assign w_shifted  = {w_sum, r_res[WIDTH-1:1]};

  // Result written on the MSB step: wrapped, or clamped toward the sign of a.
  always_comb begin
    w_res_final = w_shifted;
`ifdef SERIAL_SUB_SATURATE_EN
    if (w_ovf) begin
      if (r_a[0]) begin
        w_res_final = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        w_res_final = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      w_res_final = w_shifted;
    end
`else
    w_res_final = w_shifted;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.arg_vld) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_msb_step) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (bus.res_rdy) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, serial add of a + ~b + 1, and state-decoded handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= {WIDTH{1'b0}};
      r_b       <= {WIDTH{1'b0}};
      r_res     <= {WIDTH{1'b0}};
      r_carry   <= 1'b0;
      r_cnt     <= {CNT_W{1'b0}};
      r_ovf     <= 1'b0;
      r_arg_rdy <= 1'b1;
      r_res_vld <= 1'b0;
    end else begin
      r_arg_rdy <= (w_state_nxt == ST_IDLE);
      r_res_vld <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (bus.arg_vld) begin
            r_a     <= bus.a;
            r_b     <= ~bus.b;
            r_carry <= 1'b1;
            r_cnt   <= {CNT_W{1'b0}};
          end
        end
        ST_BUSY: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_msb_step) begin
            r_res <= w_res_final;
            r_ovf <= w_ovf;
          end else begin
            r_res <= w_shifted;
          end
        end
        default: begin
          r_res <= r_res;
          r_ovf <= r_ovf;
        end
      endcase
    end
  end

  assign bus.arg_rdy  = r_arg_rdy;
  assign bus.res_vld  = r_res_vld;
  assign bus.diff     = r_res;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_serial_signed_sub_with_overflow.sv
// Directed self-checking bench for serial_signed_sub_with_overflow at WIDTH=4.
module tb_serial_signed_sub_with_overflow;
  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  serial_signed_sub_with_overflow_if #(.WIDTH(WIDTH)) bus ();

  serial_signed_sub_with_overflow #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for the result and check value, flag and latency.
  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] exp_diff, input logic exp_ovf,
                        input bit scramble);
    int lat;
    int guard;
    guard = 0;
    while (bus.arg_rdy !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check_eq({tag, "_rdy"}, {31'd0, bus.arg_rdy}, 32'd1);
    bus.a       = av;
    bus.b       = bv;
    bus.arg_vld = 1'b1;
    tick();
    bus.arg_vld = 1'b0;
    if (scramble) begin
      bus.a = ~av;
      bus.b = av ^ bv;
    end
    check_eq({tag, "_busy_rdy"}, {31'd0, bus.arg_rdy}, 32'd0);
    lat = 0;
    while (bus.res_vld !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_lat"}, lat, WIDTH);
    check_eq({tag, "_diff"}, {28'd0, bus.diff}, {28'd0, exp_diff});
    check_eq({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, exp_ovf});
  endtask

  initial begin
    logic [3:0] sd;
    logic       so;
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    bus.arg_vld = 1'b0;
    bus.a       = 4'd0;
    bus.b       = 4'd0;
    bus.res_rdy = 1'b1;
    tick();
    tick();
    check_eq("rst_arg_rdy", {31'd0, bus.arg_rdy}, 32'd1);
    check_eq("rst_res_vld", {31'd0, bus.res_vld}, 32'd0);
    check_eq("rst_diff", {28'd0, bus.diff}, 32'd0);
    check_eq("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    rst = 1'b0;
    tick();

    run_op("3m5", 4'd3, 4'd5, 4'b1110, 1'b0, 1'b0);
    tick();
    check_eq("3m5_back_idle", {31'd0, bus.arg_rdy}, 32'd1);
    check_eq("3m5_vld_low", {31'd0, bus.res_vld}, 32'd0);

`ifdef SERIAL_SUB_SATURATE_EN
    run_op("7mm1", 4'd7, 4'b1111, 4'b0111, 1'b1, 1'b0);
    run_op("m8m1", 4'b1000, 4'd1, 4'b1000, 1'b1, 1'b0);
    run_op("0mm8", 4'd0, 4'b1000, 4'b0111, 1'b1, 1'b1);
`else
    run_op("7mm1", 4'd7, 4'b1111, 4'b1000, 1'b1, 1'b0);
    run_op("m8m1", 4'b1000, 4'd1, 4'b0111, 1'b1, 1'b0);
    run_op("0mm8", 4'd0, 4'b1000, 4'b1000, 1'b1, 1'b1);
`endif
    run_op("m8mm8", 4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0);

    // Backpressure: 6 - 2 = 4, held for ten cycles.
    tick();
    bus.res_rdy = 1'b0;
    run_op("bp", 4'd6, 4'd2, 4'd4, 1'b0, 1'b0);
    sd = bus.diff;
    so = bus.overflow;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_vld", {31'd0, bus.res_vld}, 32'd1);
      check_eq("bp_diff", {28'd0, bus.diff}, 32'd4);
      check_eq("bp_ovf", {31'd0, bus.overflow}, 32'd0);
      check_eq("bp_arg_rdy", {31'd0, bus.arg_rdy}, 32'd0);
    end
    bus.res_rdy = 1'b1;
    tick();
    check_eq("bp_release_rdy", {31'd0, bus.arg_rdy}, 32'd1);
    check_eq("bp_release_vld", {31'd0, bus.res_vld}, 32'd0);
    check_eq("bp_held_diff", {28'd0, sd}, 32'd4);
    check_eq("bp_held_ovf", {31'd0, so}, 32'd0);

    // Reset during BUSY discards the partial result.
    tick();
    bus.a       = 4'd3;
    bus.b       = 4'd5;
    bus.arg_vld = 1'b1;
    tick();
    bus.arg_vld = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_arg_rdy", {31'd0, bus.arg_rdy}, 32'd1);
    check_eq("mid_rst_res_vld", {31'd0, bus.res_vld}, 32'd0);
    check_eq("mid_rst_diff", {28'd0, bus.diff}, 32'd0);
    check_eq("mid_rst_ovf", {31'd0, bus.overflow}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("mid_rst_no_vld", {31'd0, bus.res_vld}, 32'd0);
    end
    run_op("m3m2", 4'b1101, 4'd2, 4'b1011, 1'b0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
